ws2812b_frame_sched: RTL and testbench

- Frame controller for the WS2812B pixel serializer.
- Holds a double-buffered pixel store written from the CPU/I2C side.
- Streams one frame of NUM_LEDS 24-bit GRB words to the serializer over a valid/ready handshake, then holds the mandatory low latch gap.
- Schedules commit-driven and periodic auto-refresh frames, so the serializer never sees a half-updated frame.

---
 rtl/ws2812b_frame_sched.sv | 183 ++++++++++++++++++
 tb/tb_ws2812b_frame_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_frame_sched.sv
// WS2812B frame scheduler: double-buffered pixel store, one GRB frame per start, then a latch gap (WS2812B_GAMMA_EN adds gamma).
// Latency: frame start to first pix_valid is 2 cycles (3 with WS2812B_GAMMA_EN); at least 2 cycles per pixel.
// Backpressure: pix_data is held while pix_valid && !pix_ready; the latch gap waits for ser_busy to fall.
module ws2812b_frame_sched #(
    parameter int NUM_LEDS       = 120,
    parameter int ADDR_W         = 7,
    parameter int LATCH_CYCLES   = 3000,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              glbl_reset,
    input  logic              enable,
    input  logic              auto_refresh,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              commit,
    output logic [23:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    input  logic              ser_busy,
    output logic              busy,
    output logic              commit_pending,
    output logic              frame_done,
    output logic [15:0]       frame_count
);
    localparam int MEM_AW = $clog2(2 * NUM_LEDS);
    localparam int LW     = $clog2(LATCH_CYCLES + 1);
    localparam int RW     = $clog2(REFRESH_CYCLES + 1);
    localparam logic [ADDR_W:0]   NUM_W        = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_LEDS - 1);
    localparam logic [LW-1:0]     LATCH_LOAD   = LW'(LATCH_CYCLES - 1);
    localparam logic [RW-1:0]     REFRESH_LOAD = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
`ifdef WS2812B_GAMMA_EN
        FETCH2,
`endif
        SEND,
        DRAIN,
        LATCH
    } state_t;

    state_t            state_q, state_d;
    logic              front_q;
    logic [ADDR_W-1:0] idx_q;
    logic [LW-1:0]     latch_q;
    logic [RW-1:0]     refresh_q;
    logic              start, swap, advance, latch_load;
    logic              wr_ok;
    logic [MEM_AW-1:0] wr_ptr, rd_ptr;
    logic [23:0]       mem [2*NUM_LEDS];
    logic [23:0]       rd_q;

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        advance    = 1'b0;
        latch_load = 1'b0;
        frame_done = 1'b0;
        pix_valid  = 1'b0;
        pix_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (commit_pending || (auto_refresh && refresh_q == '0))) begin
                    start   = 1'b1;
                    state_d = FETCH;
                end
            end
`ifdef WS2812B_GAMMA_EN
            FETCH:  state_d = FETCH2;
            FETCH2: state_d = SEND;
`else
            FETCH:  state_d = SEND;
`endif
            SEND: begin
                pix_valid = 1'b1;
                pix_last  = (idx_q == LAST_IDX);
                if (pix_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        advance = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (!ser_busy) begin
                    latch_load = 1'b1;
                    state_d    = LATCH;
                end
            end
            LATCH: begin
                if (latch_q == '0) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign swap = start && commit_pending;

    always_ff @(posedge clk) begin
        if (glbl_reset) begin
            state_q        <= IDLE;
            front_q        <= 1'b0;
            idx_q          <= '0;
            latch_q        <= '0;
            refresh_q      <= '0;
            commit_pending <= 1'b0;
            frame_count    <= '0;
        end else begin
            state_q <= state_d;
            if (swap)
                front_q <= ~front_q;
            // A commit landing in the swap cycle belongs to the next frame.
            if (commit)
                commit_pending <= 1'b1;
            else if (swap)
                commit_pending <= 1'b0;
            if (start)
                idx_q <= '0;
            else if (advance)
                idx_q <= idx_q + ADDR_W'(1);
            if (start)
                refresh_q <= REFRESH_LOAD;
            else if (refresh_q != '0)
                refresh_q <= refresh_q - RW'(1);
            if (latch_load)
                latch_q <= LATCH_LOAD;
            else if (state_q == LATCH && latch_q != '0)
                latch_q <= latch_q - LW'(1);
            if (frame_done)
                frame_count <= frame_count + 16'd1;
        end
    end

    // Bank 0 occupies entries [0, NUM_LEDS), bank 1 the next NUM_LEDS entries.
    assign wr_ok  = wr_en && ({1'b0, wr_addr} < NUM_W);
    assign wr_ptr = MEM_AW'(wr_addr) + (front_q ? MEM_AW'(0) : MEM_AW'(NUM_LEDS));
    assign rd_ptr = MEM_AW'(idx_q) + (front_q ? MEM_AW'(NUM_LEDS) : MEM_AW'(0));

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (glbl_reset)
            rd_q <= '0;
        else if (state_q == FETCH)
            rd_q <= mem[rd_ptr];
    end

`ifdef WS2812B_GAMMA_EN
    function automatic logic [7:0] gamma8(input logic [7:0] c);
        logic [15:0] sq;
        sq = ({8'd0, c} * {8'd0, c}) + 16'd255;
        return 8'(sq >> 8);
    endfunction

    logic [23:0] gam_q;

    always_ff @(posedge clk) begin
        if (glbl_reset)
            gam_q <= '0;
        else if (state_q == FETCH2)
            gam_q <= {gamma8(rd_q[23:16]), gamma8(rd_q[15:8]), gamma8(rd_q[7:0])};
    end

    assign pix_data = gam_q;
`else
    assign pix_data = rd_q;
`endif

endmodule

// File: tb/tb_ws2812b_frame_sched.sv
// Directed bench for ws2812b_frame_sched: NUM_LEDS=4, LATCH_CYCLES=10, REFRESH_CYCLES=100.
// A negedge monitor logs handshakes, frame starts and frame_done pulses with their cycle numbers.
`timescale 1ns/1ps
module tb_ws2812b_frame_sched;
    localparam int NUM_LEDS       = 4;
    localparam int ADDR_W         = 7;
    localparam int LATCH_CYCLES   = 10;
    localparam int REFRESH_CYCLES = 100;
`ifdef WS2812B_GAMMA_EN
    localparam int FETCH_LEN = 2;
`else
    localparam int FETCH_LEN = 1;
`endif

    logic              clk = 1'b0;
    logic              glbl_reset;
    logic              enable;
    logic              auto_refresh;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              commit;
    logic [23:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;
    logic              ser_busy;
    logic              busy;
    logic              commit_pending;
    logic              frame_done;
    logic [15:0]       frame_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [23:0] seen_dat [$];
    logic        seen_last[$];
    int          seen_cyc [$];
    int          done_cyc [$];
    int          start_cyc[$];
    logic        prev_busy = 1'b0;

    ws2812b_frame_sched #(
        .NUM_LEDS      (NUM_LEDS),
        .ADDR_W        (ADDR_W),
        .LATCH_CYCLES  (LATCH_CYCLES),
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) dut (
        .clk           (clk),
        .glbl_reset    (glbl_reset),
        .enable        (enable),
        .auto_refresh  (auto_refresh),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_last      (pix_last),
        .ser_busy      (ser_busy),
        .busy          (busy),
        .commit_pending(commit_pending),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            seen_dat.push_back(pix_data);
            seen_last.push_back(pix_last);
            seen_cyc.push_back(cyc);
        end
        if (frame_done) done_cyc.push_back(cyc);
        if (busy && !prev_busy) start_cyc.push_back(cyc);
        prev_busy = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected serializer word for a stored pixel.
    function automatic logic [23:0] gam(input logic [23:0] p);
`ifdef WS2812B_GAMMA_EN
        logic [23:0] r;
        int v;
        for (int c = 0; c < 3; c++) begin
            v = int'(p[c*8 +: 8]);
            r[c*8 +: 8] = 8'((v * v + 255) >> 8);
        end
        return r;
`else
        return p;
`endif
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_pix(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit;
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic clear_mon;
        seen_dat.delete(); seen_last.delete(); seen_cyc.delete();
        done_cyc.delete(); start_cyc.delete();
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < 2000 && done_cyc.size() < n; k++) tick();
    endtask

    task automatic test_reset;
        glbl_reset = 1'b1;
        tick(3);
        tests_run++; if (pix_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        tests_run++; if (pix_last !== 1'b0) begin tests_failed++; $display("FAIL reset_pix_last: got %b expected 0", pix_last); end
        tests_run++; if (pix_data !== 24'h0) begin tests_failed++; $display("FAIL reset_pix_data: got %h expected 000000", pix_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (commit_pending !== 1'b0) begin tests_failed++; $display("FAIL reset_commit_pending: got %b expected 0", commit_pending); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        tests_run++; if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        glbl_reset = 1'b0;
        tick(2);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic_frame;
        logic [23:0] pa [4] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        logic [23:0] got;
        clear_mon();
        for (int i = 0; i < 4; i++) write_pix(ADDR_W'(i), pa[i]);
        pulse_commit();
        tests_run++; if (commit_pending !== 1'b1) begin tests_failed++; $display("FAIL basic_pending: got %b expected 1", commit_pending); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_no_start_disabled: got busy %b expected 0", busy); end
        enable = 1'b1;
        wait_frames(1);
        tests_run++; if (seen_dat.size() != 4) begin tests_failed++; $display("FAIL basic_count: got %0d pixels expected 4", seen_dat.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (seen_dat.size() > i) ? seen_dat[i] : 24'hxxxxxx;
            tests_run++; if (got !== gam(pa[i])) begin tests_failed++; $display("FAIL basic_pix%0d: got %h expected %h", i, got, gam(pa[i])); end
            tests_run++; if (seen_last.size() <= i || seen_last[i] !== (i == 3)) begin tests_failed++; $display("FAIL basic_last%0d: wrong pix_last, expected %0d", i, (i == 3)); end
        end
        tests_run++; if (seen_cyc.size() < 2 || seen_cyc[1] - seen_cyc[0] != FETCH_LEN + 1) begin tests_failed++; $display("FAIL basic_pixel_period: expected %0d cycles", FETCH_LEN + 1); end
        tests_run++; if (done_cyc.size() != 1 || seen_cyc.size() != 4 || done_cyc[0] - seen_cyc[3] != LATCH_CYCLES + 1) begin tests_failed++; $display("FAIL basic_latch_gap: done %0d entries, expected gap %0d", done_cyc.size(), LATCH_CYCLES + 1); end
        tests_run++; if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL basic_frame_count: got %0d expected 1", frame_count); end
        tests_run++; if (commit_pending !== 1'b0) begin tests_failed++; $display("FAIL basic_pending_cleared: got %b expected 0", commit_pending); end
        tick(20);
        tests_run++; if (start_cyc.size() != 1 || busy !== 1'b0) begin tests_failed++; $display("FAIL basic_no_restart: got %0d starts busy %b expected 1 start busy 0", start_cyc.size(), busy); end
    endtask

    task automatic test_deferred_commit;
        logic [23:0] pa [4] = '{24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C, 24'h3A3B3C};
        logic [23:0] pb [4] = '{24'hABCDEF, 24'h222222, 24'h333333, 24'h444444};
        logic [23:0] got;
        clear_mon();
        for (int i = 0; i < 4; i++) write_pix(ADDR_W'(i), pa[i]);
        pulse_commit();
        for (int k = 0; k < 200 && seen_dat.size() < 1; k++) tick();
        write_pix(0, 24'hABCDEF);
        pulse_commit();
        tests_run++; if (commit_pending !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL deferred_pending: got pending %b busy %b expected 1 1", commit_pending, busy); end
        wait_frames(2);
        for (int i = 0; i < 8; i++) begin
            got = (seen_dat.size() > i) ? seen_dat[i] : 24'hxxxxxx;
            tests_run++; if (got !== gam(i < 4 ? pa[i] : pb[i-4])) begin tests_failed++; $display("FAIL deferred_pix%0d: got %h expected %h", i, got, gam(i < 4 ? pa[i] : pb[i-4])); end
        end
        tests_run++; if (start_cyc.size() < 2 || done_cyc.size() < 1 || start_cyc[1] - done_cyc[0] != 2) begin tests_failed++; $display("FAIL deferred_restart: second start not 2 cycles after frame_done"); end
        tests_run++; if (frame_count !== 16'd3) begin tests_failed++; $display("FAIL deferred_frame_count: got %0d expected 3", frame_count); end
        tests_run++; if (commit_pending !== 1'b0) begin tests_failed++; $display("FAIL deferred_pending_cleared: got %b expected 0", commit_pending); end
    endtask

    task automatic test_backpressure;
        logic [23:0] pa [4] = '{24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};
        logic [23:0] got;
        clear_mon();
        for (int i = 0; i < 4; i++) write_pix(ADDR_W'(i), pa[i]);
        write_pix(4, 24'hDEADBE);
        pulse_commit();
        for (int k = 0; k < 200 && !(pix_valid && seen_dat.size() == 2); k++) tick();
        tests_run++; if (!(pix_valid && seen_dat.size() == 2)) begin tests_failed++; $display("FAIL bp_reach_pix2: got valid %b after %0d pixels", pix_valid, seen_dat.size()); end
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (pix_valid !== 1'b1 || pix_data !== gam(pa[2])) begin tests_failed++; $display("FAIL bp_hold%0d: got valid %b data %h expected 1 %h", i, pix_valid, pix_data, gam(pa[2])); end
            tick();
        end
        pix_ready = 1'b1;
        for (int k = 0; k < 200 && !(pix_valid && pix_last); k++) tick();
        ser_busy = 1'b1;
        tick(8);
        tests_run++; if (busy !== 1'b1 || pix_valid !== 1'b0 || done_cyc.size() != 0) begin tests_failed++; $display("FAIL bp_drain_wait: got busy %b valid %b dones %0d expected 1 0 0", busy, pix_valid, done_cyc.size()); end
        ser_busy = 1'b0;
        wait_frames(1);
        for (int i = 0; i < 4; i++) begin
            got = (seen_dat.size() > i) ? seen_dat[i] : 24'hxxxxxx;
            tests_run++; if (got !== gam(pa[i])) begin tests_failed++; $display("FAIL bp_pix%0d: got %h expected %h", i, got, gam(pa[i])); end
        end
        tests_run++; if (seen_cyc.size() < 3 || seen_cyc[2] - seen_cyc[1] != FETCH_LEN + 6) begin tests_failed++; $display("FAIL bp_stall_len: pixel 2 not delayed by 5 cycles"); end
        tests_run++; if (done_cyc.size() != 1 || seen_cyc.size() != 4 || done_cyc[0] - seen_cyc[3] != LATCH_CYCLES + 8) begin tests_failed++; $display("FAIL bp_drain_gap: expected frame_done %0d cycles after last handshake", LATCH_CYCLES + 8); end
        tests_run++; if (frame_count !== 16'd4) begin tests_failed++; $display("FAIL bp_frame_count: got %0d expected 4", frame_count); end
    endtask

    task automatic test_auto_refresh;
        logic [23:0] got;
        clear_mon();
        auto_refresh = 1'b1;
        for (int k = 0; k < 500 && start_cyc.size() < 3; k++) tick();
        enable = 1'b0;
        wait_frames(3);
        tick(250);
        auto_refresh = 1'b0;
        tests_run++; if (start_cyc.size() != 3) begin tests_failed++; $display("FAIL ar_starts: got %0d starts expected 3", start_cyc.size()); end
        tests_run++; if (start_cyc.size() < 2 || start_cyc[1] - start_cyc[0] != REFRESH_CYCLES) begin tests_failed++; $display("FAIL ar_spacing1: expected %0d cycles", REFRESH_CYCLES); end
        tests_run++; if (start_cyc.size() < 3 || start_cyc[2] - start_cyc[1] != REFRESH_CYCLES) begin tests_failed++; $display("FAIL ar_spacing2: expected %0d cycles", REFRESH_CYCLES); end
        tests_run++; if (done_cyc.size() != 3 || seen_dat.size() != 12) begin tests_failed++; $display("FAIL ar_last_frame: got %0d dones %0d pixels expected 3 12", done_cyc.size(), seen_dat.size()); end
        got = (seen_dat.size() > 11) ? seen_dat[11] : 24'hxxxxxx;
        tests_run++; if (got !== gam(24'hA0B0C0)) begin tests_failed++; $display("FAIL ar_pix11: got %h expected %h", got, gam(24'hA0B0C0)); end
        tests_run++; if (busy !== 1'b0 || frame_count !== 16'd7) begin tests_failed++; $display("FAIL ar_final: got busy %b count %0d expected 0 7", busy, frame_count); end
    endtask

    task automatic test_ignored_write;
        logic [23:0] pb [4] = '{24'hABCDEF, 24'h222222, 24'h333333, 24'h444444};
        logic [23:0] got;
        clear_mon();
        enable = 1'b1;
        pulse_commit();
        wait_frames(1);
        for (int i = 0; i < 4; i++) begin
            got = (seen_dat.size() > i) ? seen_dat[i] : 24'hxxxxxx;
            tests_run++; if (got !== gam(pb[i])) begin tests_failed++; $display("FAIL ignwr_pix%0d: got %h expected %h", i, got, gam(pb[i])); end
        end
        tests_run++; if (frame_count !== 16'd8) begin tests_failed++; $display("FAIL ignwr_frame_count: got %0d expected 8", frame_count); end
    endtask

    task automatic test_reset_mid_send;
        logic [23:0] pa [4] = '{24'h0F0F0F, 24'hF0F0F0, 24'h55AA55, 24'hAA55AA};
        logic [23:0] got;
        pulse_commit();
        pulse_commit();
        tests_run++; if (commit_pending !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL rst_commit_in_start: got pending %b busy %b expected 1 1", commit_pending, busy); end
        for (int k = 0; k < 50 && !pix_valid; k++) tick();
        glbl_reset = 1'b1;
        tick();
        glbl_reset = 1'b0;
        tests_run++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_idle: got valid %b busy %b expected 0 0", pix_valid, busy); end
        tests_run++; if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL rst_mid_count: got %0d expected 0", frame_count); end
        tests_run++; if (commit_pending !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_pending: got %b expected 0", commit_pending); end
        clear_mon();
        tick(5);
        tests_run++; if (start_cyc.size() != 0) begin tests_failed++; $display("FAIL rst_mid_no_start: got %0d starts expected 0", start_cyc.size()); end
        for (int i = 0; i < 4; i++) write_pix(ADDR_W'(i), pa[i]);
        pulse_commit();
        wait_frames(1);
        for (int i = 0; i < 4; i++) begin
            got = (seen_dat.size() > i) ? seen_dat[i] : 24'hxxxxxx;
            tests_run++; if (got !== gam(pa[i])) begin tests_failed++; $display("FAIL rst_after_pix%0d: got %h expected %h", i, got, gam(pa[i])); end
        end
        tests_run++; if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL rst_after_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_gamma;
        logic [23:0] exp0;
        logic [23:0] got;
`ifdef WS2812B_GAMMA_EN
        exp0 = 24'h40FF01;
`else
        exp0 = 24'h80FF01;
`endif
        clear_mon();
        write_pix(0, 24'h80FF01);
        pulse_commit();
        wait_frames(1);
        got = (seen_dat.size() > 0) ? seen_dat[0] : 24'hxxxxxx;
        tests_run++; if (got !== exp0) begin tests_failed++; $display("FAIL gamma_pix0: got %h expected %h", got, exp0); end
        tests_run++; if (start_cyc.size() < 1 || seen_cyc.size() < 1 || seen_cyc[0] - start_cyc[0] != FETCH_LEN) begin tests_failed++; $display("FAIL gamma_fetch_len: expected FETCH of %0d cycles", FETCH_LEN); end
        tests_run++; if (frame_count !== 16'd2) begin tests_failed++; $display("FAIL gamma_frame_count: got %0d expected 2", frame_count); end
    endtask

    initial begin
        glbl_reset   = 1'b1;
        enable       = 1'b0;
        auto_refresh = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        commit       = 1'b0;
        pix_ready    = 1'b1;
        ser_busy     = 1'b0;
        test_reset();
        test_basic_frame();
        test_deferred_commit();
        test_backpressure();
        test_auto_refresh();
        test_ignored_write();
        test_reset_mid_send();
        test_gamma();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
